// File: rtl/soc_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, requester ids
// and the request payload carried from a requester to the memory port.
package soc_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IFU,
        ARB_BUSY_LSU
    } arb_state_e;

    typedef enum logic {
        REQ_IFU,
        REQ_LSU
    } requester_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around the arbiter.
interface mem_arbiter_if;
    import soc_pkg::*;

    logic              ifu_reqValid;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_respValid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_err;

    logic              lsu_reqValid;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_respValid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_err;

    logic              mem_reqValid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_respValid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  ifu_reqValid, ifu_addr,
        input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_respValid, mem_rdata,
        output ifu_respValid, ifu_rdata, ifu_err,
        output lsu_respValid, lsu_rdata, lsu_err,
        output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    // Requesters and memory side.
    modport master (
        output ifu_reqValid, ifu_addr,
        output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_respValid, mem_rdata,
        input  ifu_respValid, ifu_rdata, ifu_err,
        input  lsu_respValid, lsu_rdata, lsu_err,
        input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/arb_req_slot.sv
// One-deep pending-request latch: holds a request that lost arbitration until granted.
module arb_req_slot
    import soc_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     capture,
    input  logic     clear,
    input  arb_req_t req,
    output logic     valid,
    output arb_req_t data
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            data  <= req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// one transaction in flight, with a watchdog that turns a stall into an error response.
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e       state;
    requester_e       last_grant;
    logic [CNT_W-1:0] watchdog;
    arb_req_t         hold;

    logic     pend_ifu, pend_lsu;
    arb_req_t slot_ifu, slot_lsu;
    arb_req_t live_ifu, live_lsu;
    arb_req_t fld_ifu, fld_lsu, fld_win;
    logic     idle, cand_ifu, cand_lsu, grant_ifu, grant_lsu, grant_any;
    logic     cap_ifu, cap_lsu, expired;

    // Candidate selection and request capture.
    always_comb begin
        live_ifu       = '0;
        live_ifu.addr  = bus.ifu_addr;
        live_lsu.addr  = bus.lsu_addr;
        live_lsu.wen   = bus.lsu_wen;
        live_lsu.wdata = bus.lsu_wdata;
        live_lsu.wmask = bus.lsu_wmask;

        fld_ifu = pend_ifu ? slot_ifu : live_ifu;
        fld_lsu = pend_lsu ? slot_lsu : live_lsu;

        idle      = (state == ARB_IDLE);
        cand_ifu  = pend_ifu | bus.ifu_reqValid;
        cand_lsu  = pend_lsu | bus.lsu_reqValid;
        grant_ifu = idle & cand_ifu & (~cand_lsu | (last_grant == REQ_LSU));
        grant_lsu = idle & cand_lsu & ~grant_ifu;
        grant_any = grant_ifu | grant_lsu;
        fld_win   = grant_ifu ? fld_ifu : fld_lsu;

        // Requests arriving while the slot is full or the owner is in flight are dropped.
        cap_ifu = bus.ifu_reqValid & ~pend_ifu & (state != ARB_BUSY_IFU) & ~grant_ifu;
        cap_lsu = bus.lsu_reqValid & ~pend_lsu & (state != ARB_BUSY_LSU) & ~grant_lsu;

        expired = (watchdog == CNT_W'(TIMEOUT - 1));
    end

    arb_req_slot u_slot_ifu (
        .clock   (clock),
        .reset   (reset),
        .capture (cap_ifu),
        .clear   (grant_ifu),
        .req     (live_ifu),
        .valid   (pend_ifu),
        .data    (slot_ifu)
    );

    arb_req_slot u_slot_lsu (
        .clock   (clock),
        .reset   (reset),
        .capture (cap_lsu),
        .clear   (grant_lsu),
        .req     (live_lsu),
        .valid   (pend_lsu),
        .data    (slot_lsu)
    );

    // State, round-robin pointer, watchdog and held request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_grant <= REQ_LSU;
            watchdog   <= '0;
            hold       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_ifu ? REQ_IFU : REQ_LSU;
                        hold       <= fld_win;
                        watchdog   <= '0;
                        if (!bus.mem_respValid) begin
                            state <= grant_ifu ? ARB_BUSY_IFU : ARB_BUSY_LSU;
                        end
                    end
                end
                ARB_BUSY_IFU, ARB_BUSY_LSU: begin
                    if (bus.mem_respValid || expired) begin
                        state <= ARB_IDLE;
                    end else begin
                        watchdog <= watchdog + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Memory request and response routing; zero-wait completions stay combinational.
    always_comb begin
        bus.mem_reqValid  = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wen       = 1'b0;
        bus.mem_wdata     = '0;
        bus.mem_wmask     = '0;
        bus.ifu_respValid = 1'b0;
        bus.ifu_rdata     = '0;
        bus.ifu_err       = 1'b0;
        bus.lsu_respValid = 1'b0;
        bus.lsu_rdata     = '0;
        bus.lsu_err       = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (grant_any) begin
                    bus.mem_reqValid = 1'b1;
                    bus.mem_addr     = fld_win.addr;
                    bus.mem_wen      = fld_win.wen;
                    bus.mem_wdata    = fld_win.wdata;
                    bus.mem_wmask    = fld_win.wmask;
                    if (bus.mem_respValid) begin
                        if (grant_ifu) begin
                            bus.ifu_respValid = 1'b1;
                            bus.ifu_rdata     = bus.mem_rdata;
                        end else begin
                            bus.lsu_respValid = 1'b1;
                            bus.lsu_rdata     = bus.mem_rdata;
                        end
                    end
                end
            end
            ARB_BUSY_IFU: begin
                bus.mem_addr  = hold.addr;
                bus.mem_wen   = hold.wen;
                bus.mem_wdata = hold.wdata;
                bus.mem_wmask = hold.wmask;
                if (bus.mem_respValid) begin
                    bus.ifu_respValid = 1'b1;
                    bus.ifu_rdata     = bus.mem_rdata;
                end else if (expired) begin
                    bus.ifu_respValid = 1'b1;
                    bus.ifu_err       = 1'b1;
                end
            end
            ARB_BUSY_LSU: begin
                bus.mem_addr  = hold.addr;
                bus.mem_wen   = hold.wen;
                bus.mem_wdata = hold.wdata;
                bus.mem_wmask = hold.wmask;
                if (bus.mem_respValid) begin
                    bus.lsu_respValid = 1'b1;
                    bus.lsu_rdata     = bus.mem_rdata;
                end else if (expired) begin
                    bus.lsu_respValid = 1'b1;
                    bus.lsu_err       = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// watchdog and dropped-request sequences.
module tb_mem_arbiter;

    typedef struct packed {
        logic        rst_n;
        logic        ifu_req;
        logic [31:0] ifu_addr;
        logic        lsu_req;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wmask;
        logic        mem_resp;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_req;
        logic [31:0] mem_addr;
        logic        mem_wen;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wmask;
        logic        ifu_resp;
        logic [31:0] ifu_rdata;
        logic        ifu_err;
        logic        lsu_resp;
        logic [31:0] lsu_rdata;
        logic        lsu_err;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic  clock;
    logic  reset;
    int    checks;
    int    errors;
    vec_t  vecs[$];

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic in_t inp(bit ir, logic [31:0] ia, bit lr, logic [31:0] la, bit lw,
                                logic [31:0] ld, logic [3:0] lm, bit mr, logic [31:0] md,
                                bit rn = 1'b1);
        in_t v;
        v = '{rn, ir, ia, lr, la, lw, ld, lm, mr, md};
        return v;
    endfunction

    function automatic out_t outp(bit mq, logic [31:0] ma, bit mw, logic [31:0] md,
                                  logic [3:0] mm, bit ir, logic [31:0] id, bit ie,
                                  bit lr, logic [31:0] ld, bit le);
        out_t v;
        v = '{mq, ma, mw, md, mm, ir, id, ie, lr, ld, le};
        return v;
    endfunction

    function automatic out_t sample();
        out_t v;
        v = '{bus.mem_reqValid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask,
              bus.ifu_respValid, bus.ifu_rdata, bus.ifu_err,
              bus.lsu_respValid, bus.lsu_rdata, bus.lsu_err};
        return v;
    endfunction

    task automatic add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        vecs.push_back(v);
    endtask

    task automatic drive(in_t v);
        reset             = v.rst_n;
        bus.ifu_reqValid  = v.ifu_req;
        bus.ifu_addr      = v.ifu_addr;
        bus.lsu_reqValid  = v.lsu_req;
        bus.lsu_addr      = v.lsu_addr;
        bus.lsu_wen       = v.lsu_wen;
        bus.lsu_wdata     = v.lsu_wdata;
        bus.lsu_wmask     = v.lsu_wmask;
        bus.mem_respValid = v.mem_resp;
        bus.mem_rdata     = v.mem_rdata;
    endtask

    task automatic check(string name, logic [137:0] act, logic [137:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next-cycle inputs go in at the falling edge; outputs are compared 1 time unit later.
    task automatic step(in_t v);
        @(negedge clock);
        drive(v);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        in_t  none;
        out_t zero;
        int   lat;

        clock  = 1'b0;
        checks = 0;
        errors = 0;
        none   = inp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero   = outp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(none);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // inp(ifu_req, ifu_addr, lsu_req, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, mem_resp, mem_rdata [, rst_n])
        // outp(mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_resp, ifu_rdata, ifu_err, lsu_resp, lsu_rdata, lsu_err)
        add("reset_idle", none, zero);
        add("ifu_zero_wait", inp(1, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 32'h13),
            outp(1, 32'h8000_0000, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0));
        add("stray_resp_idle", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'h55), zero);
        add("reset_again", inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero);
        add("tie_ifu_first", inp(1, 32'h200, 1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0),
            outp(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ifu_busy_hold", none, outp(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ifu_resp", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001),
            outp(0, 32'h200, 0, 0, 0, 1, 32'hCAFE_0001, 0, 0, 0, 0));
        add("lsu_store_grant", none, outp(1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0));
        add("lsu_busy_hold", none, outp(0, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0));
        add("lsu_store_resp", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234),
            outp(0, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1, 32'h1234, 0));
        add("idle_after_store", none, zero);
        add("lsu_load_grant", inp(0, 0, 1, 32'h300, 0, 0, 0, 0, 0),
            outp(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("wd0_ifu_capture", inp(1, 32'h500, 0, 0, 0, 0, 0, 0, 0),
            outp(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("wd1", none, outp(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("wd2", none, outp(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("lsu_timeout", none, outp(0, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        add("ifu_after_timeout", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'h77),
            outp(1, 32'h500, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0));
        add("rr_lsu", inp(1, 32'h10, 1, 32'h20, 0, 0, 0, 1, 32'h1),
            outp(1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0));
        add("rr_ifu", inp(0, 0, 1, 32'h24, 0, 0, 0, 1, 32'h2),
            outp(1, 32'h10, 0, 0, 0, 1, 32'h2, 0, 0, 0, 0));
        add("rr_lsu2", inp(1, 32'h14, 0, 0, 0, 0, 0, 1, 32'h3),
            outp(1, 32'h24, 0, 0, 0, 0, 0, 0, 1, 32'h3, 0));
        add("rr_ifu2", inp(0, 0, 1, 32'h28, 0, 0, 0, 1, 32'h4),
            outp(1, 32'h14, 0, 0, 0, 1, 32'h4, 0, 0, 0, 0));
        add("rr_lsu3", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'h5),
            outp(1, 32'h28, 0, 0, 0, 0, 0, 0, 1, 32'h5, 0));
        add("rr_drained", none, zero);
        add("lsu_grant_pre_rst", inp(0, 0, 1, 32'h600, 1, 32'h11, 4'h3, 0, 0),
            outp(1, 32'h600, 1, 32'h11, 4'h3, 0, 0, 0, 0, 0, 0));
        add("rst_mid_busy", inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            outp(0, 32'h600, 1, 32'h11, 4'h3, 0, 0, 0, 0, 0, 0));
        add("stray_after_rst", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'h99), zero);
        add("quiet_after_rst", none, zero);
        add("ifu_addr0_grant", inp(1, 32'h0, 0, 0, 0, 0, 0, 0, 0),
            outp(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ifu_dup_dropped", inp(1, 32'h4, 0, 0, 0, 0, 0, 0, 0), zero);
        add("ifu_addr0_resp", inp(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA),
            outp(0, 32'h0, 0, 0, 0, 1, 32'hAAAA, 0, 0, 0, 0));
        add("no_dup_grant", none, zero);
        add("no_dup_grant2", none, zero);

        foreach (vecs[k]) begin
            step(vecs[k].i);
            check($sformatf("%s[%0d]", vecs[k].name, k), sample(), vecs[k].o);
        end

        // IFU timeout measured with a bounded wait.
        step(inp(1, 32'h700, 0, 0, 0, 0, 0, 0, 0));
        check("to_grant_req", {bus.mem_reqValid, bus.mem_addr}, {1'b1, 32'h700});
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            step(none);
            if (bus.ifu_respValid) begin
                lat = c;
                break;
            end
        end
        check("to_latency", 138'(lat), 138'(4));
        check("to_err_rdata", {bus.ifu_err, bus.ifu_rdata, bus.lsu_respValid},
              {1'b1, 32'h0, 1'b0});

        // LSU request while its slot is already full is dropped.
        step(inp(1, 32'hA00, 0, 0, 0, 0, 0, 0, 0));
        check("dup_ifu_grant", {bus.mem_reqValid, bus.mem_addr}, {1'b1, 32'hA00});
        step(inp(0, 0, 1, 32'h800, 0, 0, 0, 0, 0));
        step(inp(0, 0, 1, 32'h900, 0, 0, 0, 0, 0));
        step(inp(0, 0, 0, 0, 0, 0, 0, 1, 32'h1));
        check("dup_ifu_resp", {bus.ifu_respValid, bus.ifu_rdata, bus.lsu_respValid},
              {1'b1, 32'h1, 1'b0});
        step(inp(0, 0, 0, 0, 0, 0, 0, 1, 32'hBB));
        check("dup_lsu_slot", {bus.mem_reqValid, bus.mem_addr, bus.lsu_respValid, bus.lsu_rdata},
              {1'b1, 32'h800, 1'b1, 32'hBB});
        step(none);
        check("dup_lsu_dropped", 138'(sample()), 138'(zero));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
